// File: rtl/remainder.sv
// Divider working register: remainder in the upper half, dividend/quotient
// bits in the lower half, updated from the ALU one step per clock.
module remainder (
  input  logic        clk,
  input  logic        Reset,
  input  logic        SRL_ctrl,
  input  logic        W_ctrl,
  input  logic        Ready,
  input  logic        ALU_carry,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Multiplier_in,
  output logic [63:0] Product_out
);

  logic [63:0] r;
  logic [31:0] upper;
  logic [63:0] init_val;
  logic [63:0] shift_val;
  logic [63:0] write_val;

  assign upper     = W_ctrl ? ALU_result : r[63:32];
  assign init_val  = W_ctrl ? {32'h0, Multiplier_in} : 64'h0;
  // Write and shift share one edge: the ALU result lands shifted right.
  assign shift_val = {ALU_carry, upper, r[31:1]};
  assign write_val = {ALU_result, r[31:0]};

  always_ff @(posedge clk) begin
    if (Reset) begin
      r <= init_val;
    end else if (!Ready) begin
      if (SRL_ctrl) begin
        r <= shift_val;
      end else if (W_ctrl) begin
        r <= write_val;
      end
    end
  end

  assign Product_out = r;

endmodule

// File: tb/tb_remainder.sv
// Directed bench for remainder: literal test-plan values plus a
// reference model compared on every falling edge.
module tb_remainder;

  logic        clk = 1'b0;
  logic        Reset;
  logic        SRL_ctrl;
  logic        W_ctrl;
  logic        Ready;
  logic        ALU_carry;
  logic [31:0] ALU_result;
  logic [31:0] Multiplier_in;
  logic [63:0] Product_out;

  int checks = 0;
  int passed = 0;

  logic [63:0] model;
  bit          model_valid = 1'b0;

  remainder dut (
    .clk          (clk),
    .Reset        (Reset),
    .SRL_ctrl     (SRL_ctrl),
    .W_ctrl       (W_ctrl),
    .Ready        (Ready),
    .ALU_carry    (ALU_carry),
    .ALU_result   (ALU_result),
    .Multiplier_in(Multiplier_in),
    .Product_out  (Product_out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] next_val(
    input logic [63:0] cur,
    input logic rst, input logic w, input logic s, input logic rdy,
    input logic c, input logic [31:0] alu, input logic [31:0] mi);
    logic [63:0] hi;
    logic [63:0] lo;
    logic [63:0] cb;
    if (rst) return w ? {32'h0, mi} : 64'h0;
    if (rdy) return cur;
    if (s) begin
      hi = w ? {32'h0, alu} : (cur >> 32);
      lo = {32'h0, cur[31:0]} >> 1;
      cb = {63'h0, c};
      return (cb << 63) | (hi << 31) | lo;
    end
    if (w) return ({32'h0, alu} << 32) | {32'h0, cur[31:0]};
    return cur;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (Reset) model_valid <= 1'b1;
    model <= next_val(model, Reset, W_ctrl, SRL_ctrl, Ready,
                      ALU_carry, ALU_result, Multiplier_in);
  end

  always @(negedge clk) begin
    if (model_valid) check("model", Product_out, model);
  end

  task automatic step(input logic rst, input logic w, input logic s,
                      input logic rdy, input logic c,
                      input logic [31:0] alu, input logic [31:0] mi);
    @(negedge clk);
    Reset = rst;
    W_ctrl = w;
    SRL_ctrl = s;
    Ready = rdy;
    ALU_carry = c;
    ALU_result = alu;
    Multiplier_in = mi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    W_ctrl = 1'b0;
    SRL_ctrl = 1'b0;
    Ready = 1'b0;
    ALU_carry = 1'b0;
    ALU_result = 32'h0;
    Multiplier_in = 32'h0;
    @(posedge clk);
    #1;
    check("reset_clear", Product_out, 64'h0);

    step(1, 1, 0, 0, 0, 32'h0, 32'hFFFF_FFFF);
    check("init_load", Product_out, 64'h0000_0000_FFFF_FFFF);
    step(0, 1, 1, 0, 1, 32'd10, 32'h0);
    check("write_shift", Product_out, 64'h8000_0005_7FFF_FFFF);
    step(0, 0, 1, 0, 0, 32'h0, 32'h0);
    check("shift_only", Product_out, 64'h4000_0002_BFFF_FFFF);

    step(1, 0, 1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("clear_prio", Product_out, 64'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1'($urandom), 1'($urandom), 1, 1'($urandom),
           $urandom, $urandom);
      check("ready_hold", Product_out, 64'h0);
    end

    step(1, 1, 0, 0, 0, 32'h0, 32'h1234_5678);
    check("load_1234", Product_out, 64'h0000_0000_1234_5678);
    step(0, 1, 0, 0, 1, 32'hDEAD_BEEF, 32'h0);
    check("write_only", Product_out, 64'hDEAD_BEEF_1234_5678);
    step(0, 0, 0, 0, 1, 32'h5555_5555, 32'h0);
    check("idle_hold", Product_out, 64'hDEAD_BEEF_1234_5678);

    step(0, 0, 1, 0, 1, 32'h0, 32'h0);
    check("shift_c1", Product_out, 64'hEF56_DF77_891A_2B3C);
    step(0, 1, 1, 0, 0, 32'h0000_0003, 32'h0);
    check("wshift_c0", Product_out, 64'h0000_0001_C48D_159E);
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF, 32'h0);
    check("ready_hold2", Product_out, 64'h0000_0001_C48D_159E);
    step(0, 0, 1, 0, 1, 32'h0, 32'h0);
    check("resume", Product_out, 64'h8000_0000_E246_8ACF);

    step(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h0000_0007);
    check("reset_mid", Product_out, 64'h0000_0000_0000_0007);

    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) == 0), 1'($urandom),
           $urandom, $urandom);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
